cmp_trip_detector: RTL and testbench
====================================

Name: cmp_trip_detector

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Consumes the comparator's one-hot lesser/greater/equal flags, qualified by a sample-valid strobe.
- Debounces them into a hysteretic trip state: DEBOUNCE consecutive "greater" samples trip the block, and DEBOUNCE consecutive "lesser" samples release it.
- Emits a registered level output and single-cycle event pulses for control logic further down.

Parameters:
- DEBOUNCE, 3, number of consecutive qualifying valid samples needed to trip or release; legal range 1..15.
- CNT_W, 8, width of the optional trip-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  flags are sampled only on cycles where this is 1.
- lesser  input  1  comparator Lesser flag (a<b).
- greater  input  1  comparator Greater flag (a>b).
- equal  input  1  comparator Equal flag (a==b).
- clear  input  1  synchronous clear; returns block to IDLE.
- tripped  output  1  registered trip level.
- trip_pulse  output  1  one-cycle pulse on entry to TRIPPED.
- release_pulse  output  1  one-cycle pulse on exit from TRIPPED to IDLE.
- flag_err  output  1  one-cycle pulse when a valid sample's flags are not exactly one-hot.
- trip_count  output  CNT_W  number of trips since reset/clear; present only with CMP_TRIP_COUNT_EN.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, run counter=0, and all outputs 0 (including trip_count).
- Decided: one clock (clk); reset rst is asynchronous, active-high.
- All outputs are registered; pulses are high for exactly one clk cycle.
- States:
  - IDLE: tripped=0.
  - ARM_HI: counting greater samples; tripped=0.
  - TRIPPED: tripped=1.
  - ARM_LO: counting lesser samples; tripped=1.
- Run counter is 4 bits.
- Qualifying valid samples:
  - Valid greater in IDLE/ARM_HI: counter increments. The edge that samples the DEBOUNCE-th consecutive greater moves to TRIPPED, clears the counter, and sets trip_pulse=1 for the following cycle. Otherwise IDLE moves to ARM_HI.
  - Valid lesser in TRIPPED/ARM_LO: symmetric. The DEBOUNCE-th consecutive lesser moves to IDLE with release_pulse=1.
- Run-breaking valid samples:
  - Valid equal, or the opposite flag (lesser in ARM_HI, greater in ARM_LO): counter=0 and state falls back to IDLE or TRIPPED respectively.
  - Valid greater in TRIPPED and valid lesser in IDLE: no change, counter stays 0.
- in_valid=0: state, counter and tripped hold; pulses deassert. Gaps do not break a run.
- Non-one-hot flags on a valid sample (zero or more than one set): treated as equal (run broken), and flag_err=1 next cycle.
- clear=1: next edge forces IDLE, counter=0, tripped=0, pulses=0, trip_count=0. clear has priority over in_valid. No release_pulse is generated by clear.
- DEBOUNCE=1: a single valid greater trips on that edge; a single lesser releases.
- Reset mid-run: abandons the count immediately; no pulse on reset exit.

Optional Feature:
- Macro: CMP_TRIP_COUNT_EN.
- Defined: trip_count port exists. It increments on every IDLE/ARM_HI→TRIPPED transition, saturates at all-ones, and is zeroed by rst or clear.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- DEBOUNCE=3; valid greater,greater,greater → tripped=1 and trip_pulse=1 on the cycle after the 3rd sample edge; trip_pulse=0 on the next cycle.
- DEBOUNCE=3; greater,greater,equal,greater,greater → no trip; one further greater → trip.
- Tripped; lesser,invalid-gap(in_valid=0 for 2 cycles),lesser,lesser → release_pulse=1 once and tripped=0; a following greater does not retrip before 3 greaters.
- Valid sample with lesser=1 and greater=1 → flag_err=1 for one cycle; run counter=0; state unchanged at IDLE.
- Tripped; assert clear together with a valid lesser → IDLE, tripped=0, release_pulse=0, trip_count=0. Separately, rst asserted asynchronously mid-ARM_HI → all outputs 0 without waiting for clk.
- With CMP_TRIP_COUNT_EN and CNT_W=2: cause 5 trips → trip_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/cmp_trip_detector.sv
// -----------------------------------------------------------------------------
// cmp_trip_detector
//
// Purpose:
//   Sits directly behind the 4-bit magnitude comparator. Debounces the
//   comparator's one-hot lesser/greater/equal flags into a hysteretic trip
//   state: DEBOUNCE consecutive valid "greater" samples trip the block and
//   DEBOUNCE consecutive valid "lesser" samples release it. Samples are only
//   taken when in_valid is high; cycles with in_valid low do not break a run.
//
// Parameters:
//   DEBOUNCE  consecutive qualifying samples needed to trip/release (1..15)
//   CNT_W     width of the optional trip-event counter
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   in_valid       flags are sampled only when this is 1
//   lesser         comparator a<b flag
//   greater        comparator a>b flag
//   equal          comparator a==b flag
//   clear          synchronous clear back to IDLE (priority over in_valid)
//   tripped        registered trip level
//   trip_pulse     one-cycle pulse on entry to TRIPPED
//   release_pulse  one-cycle pulse on exit from TRIPPED to IDLE
//   flag_err       one-cycle pulse when a valid sample is not one-hot
//   dbg_state      current FSM state (IDLE=0, ARM_HI=1, TRIPPED=2, ARM_LO=3)
//   trip_count     saturating trip counter (only with CMP_TRIP_COUNT_EN)
//
// Handshake: there is no back-pressure. A sample is consumed on every rising
// clk edge where in_valid=1; the block is always ready.
//
// Configuration macro:
//   CMP_TRIP_COUNT_EN  adds the trip_count port and its saturating counter.
// -----------------------------------------------------------------------------
module cmp_trip_detector #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             lesser,
  input  logic             greater,
  input  logic             equal,
  input  logic             clear,
  output logic             tripped,
  output logic             trip_pulse,
  output logic             release_pulse,
  output logic             flag_err,
  output logic [1:0]       dbg_state
`ifdef CMP_TRIP_COUNT_EN
  ,
  output logic [CNT_W-1:0] trip_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_HI  = 2'd1,
    TRIPPED = 2'd2,
    ARM_LO  = 2'd3
  } state_e;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  state_e     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic       tripped_q, tripped_d;
  logic       trip_pulse_q, trip_pulse_d;
  logic       release_pulse_q, release_pulse_d;
  logic       flag_err_q, flag_err_d;

  logic       one_hot;
  logic       greater_ok;
  logic       lesser_ok;
  logic [3:0] run_inc;
  logic       run_hit;

  // A non-one-hot sample is treated exactly like "equal": it only ever
  // breaks a run, never extends one.
  assign one_hot    = (lesser & ~greater & ~equal) |
                      (~lesser & greater & ~equal) |
                      (~lesser & ~greater & equal);
  assign greater_ok = one_hot & greater;
  assign lesser_ok  = one_hot & lesser;

  // run_q never reaches DEB (it is cleared on the hitting edge), so the
  // increment cannot wrap for DEBOUNCE <= 15.
  assign run_inc = run_q + 4'd1;
  assign run_hit = (run_inc == DEB);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clear) begin
      state_d = IDLE;
      run_d   = 4'd0;
    end else if (in_valid) begin
      unique case (state_q)
        IDLE, ARM_HI: begin
          if (greater_ok) begin
            if (run_hit) begin
              state_d = TRIPPED;
              run_d   = 4'd0;
            end else begin
              state_d = ARM_HI;
              run_d   = run_inc;
            end
          end else begin
            // lesser, equal or malformed flags: no run toward a trip
            state_d = IDLE;
            run_d   = 4'd0;
          end
        end
        TRIPPED, ARM_LO: begin
          if (lesser_ok) begin
            if (run_hit) begin
              state_d = IDLE;
              run_d   = 4'd0;
            end else begin
              state_d = ARM_LO;
              run_d   = run_inc;
            end
          end else begin
            state_d = TRIPPED;
            run_d   = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    tripped_d       = (state_d == TRIPPED) || (state_d == ARM_LO);
    trip_pulse_d    = 1'b0;
    release_pulse_d = 1'b0;
    flag_err_d      = 1'b0;
    if (!clear && in_valid) begin
      trip_pulse_d    = ((state_q == IDLE) || (state_q == ARM_HI)) &&
                        (state_d == TRIPPED);
      release_pulse_d = ((state_q == TRIPPED) || (state_q == ARM_LO)) &&
                        (state_d == IDLE);
      flag_err_d      = ~one_hot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tripped_q       <= 1'b0;
      trip_pulse_q    <= 1'b0;
      release_pulse_q <= 1'b0;
      flag_err_q      <= 1'b0;
    end else begin
      tripped_q       <= tripped_d;
      trip_pulse_q    <= trip_pulse_d;
      release_pulse_q <= release_pulse_d;
      flag_err_q      <= flag_err_d;
    end
  end

  assign tripped       = tripped_q;
  assign trip_pulse    = trip_pulse_q;
  assign release_pulse = release_pulse_q;
  assign flag_err      = flag_err_q;
  assign dbg_state     = state_q;

`ifdef CMP_TRIP_COUNT_EN
  // ---------------------------------------------------------------------------
  // Saturating trip counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (trip_pulse_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign trip_count = count_q;
`endif

endmodule

// File: tb/tb_cmp_trip_detector.sv
// -----------------------------------------------------------------------------
// tb_cmp_trip_detector
//
// Drives two instances from the same stimulus: DEBOUNCE=3 (main) and
// DEBOUNCE=1 (boundary). A behavioural model (trip level + run length per
// instance) predicts every cycle's outputs into exp_q / exp1_q; one compare
// process checks them. Directed sequences add literal expectations, then a
// randomized phase runs. Define CMP_TRIP_COUNT_EN to cover trip_count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmp_trip_detector;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CMP_TRIP_COUNT_EN
  localparam int EW = 4 + CNT_W;
`else
  localparam int EW = 4;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, lesser = 1'b0, greater = 1'b0, equal = 1'b0;
  logic clear = 1'b0;

  logic tripped0, trip_pulse0, release_pulse0, flag_err0;
  logic tripped1, trip_pulse1, release_pulse1, flag_err1;
  logic [1:0] dbg0, dbg1;
`ifdef CMP_TRIP_COUNT_EN
  logic [CNT_W-1:0] count0, count1;
`endif

  cmp_trip_detector #(.DEBOUNCE(3), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .lesser(lesser),
    .greater(greater), .equal(equal), .clear(clear),
    .tripped(tripped0), .trip_pulse(trip_pulse0),
    .release_pulse(release_pulse0), .flag_err(flag_err0),
    .dbg_state(dbg0)
`ifdef CMP_TRIP_COUNT_EN
    , .trip_count(count0)
`endif
  );

  cmp_trip_detector #(.DEBOUNCE(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .lesser(lesser),
    .greater(greater), .equal(equal), .clear(clear),
    .tripped(tripped1), .trip_pulse(trip_pulse1),
    .release_pulse(release_pulse1), .flag_err(flag_err1),
    .dbg_state(dbg1)
`ifdef CMP_TRIP_COUNT_EN
    , .trip_count(count1)
`endif
  );

  logic [EW-1:0] got0, got1;
`ifdef CMP_TRIP_COUNT_EN
  assign got0 = {tripped0, trip_pulse0, release_pulse0, flag_err0, count0};
  assign got1 = {tripped1, trip_pulse1, release_pulse1, flag_err1, count1};
`else
  assign got0 = {tripped0, trip_pulse0, release_pulse0, flag_err0};
  assign got1 = {tripped1, trip_pulse1, release_pulse1, flag_err1};
`endif

  // ---------------------------------------------------------------------------
  // Behavioural model: per instance, a trip level plus the length of the
  // current run of samples pushing toward the other level.
  // ---------------------------------------------------------------------------
  int deb [2] = '{3, 1};
  bit m_trip [2];
  int m_run  [2];
  bit m_tp   [2];
  bit m_rp   [2];
  bit m_fe   [2];
  int m_cnt  [2];

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp1_q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [EW-1:0] model_out(int k);
    logic [EW-1:0] r;
`ifdef CMP_TRIP_COUNT_EN
    r = {m_trip[k], m_tp[k], m_rp[k], m_fe[k], CNT_W'(m_cnt[k])};
`else
    r = {m_trip[k], m_tp[k], m_rp[k], m_fe[k]};
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_trip[k] = 0; m_run[k] = 0; m_tp[k] = 0;
      m_rp[k] = 0; m_fe[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step(bit v, bit l, bit g, bit e, bit c);
    int  ones;
    bit  toward;
    ones = int'(l) + int'(g) + int'(e);
    for (int k = 0; k < 2; k++) begin
      m_tp[k] = 0; m_rp[k] = 0; m_fe[k] = 0;
      if (c) begin
        m_trip[k] = 0; m_run[k] = 0; m_cnt[k] = 0;
      end else if (v) begin
        m_fe[k] = (ones != 1);
        // a sample pushes toward the other level only if it is a clean
        // greater (while low) or a clean lesser (while high)
        toward = (ones == 1) && (m_trip[k] ? l : g);
        if (toward) begin
          m_run[k]++;
          if (m_run[k] == deb[k]) begin
            m_run[k] = 0;
            m_trip[k] = !m_trip[k];
            if (m_trip[k]) begin
              m_tp[k] = 1;
              if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
            end else begin
              m_rp[k] = 1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
      end
    end
    exp_q.push_back(model_out(0));
    exp1_q.push_back(model_out(1));
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard compare process: checks both instances every driven cycle,
  // 1 ns after the rising edge.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    logic [EW-1:0] e0, e1;
    #1;
    if (exp_q.size() > 0) begin
      e0 = exp_q.pop_front();
      checks++;
      if (got0 !== e0) begin
        errors++;
        $display("FAIL deb3_cycle t=%0t got=%b expected=%b", $time, got0, e0);
      end
    end
    if (exp1_q.size() > 0) begin
      e1 = exp1_q.pop_front();
      checks++;
      if (got1 !== e1) begin
        errors++;
        $display("FAIL deb1_cycle t=%0t got=%b expected=%b", $time, got1, e1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic lit(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Applies one sample at the falling edge and returns 1 ns after the
  // rising edge that consumed it.
  task automatic step(bit v, bit l, bit g, bit e, bit c);
    @(negedge clk);
    in_valid = v; lesser = l; greater = g; equal = e; clear = c;
    model_step(v, l, g, e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic gt();   step(1, 0, 1, 0, 0); endtask
  task automatic lt();   step(1, 1, 0, 0, 0); endtask
  task automatic eq();   step(1, 0, 0, 1, 0); endtask
  task automatic gap();  step(0, 0, 0, 0, 0); endtask
  task automatic clr();  step(0, 0, 0, 0, 1); endtask

  task automatic release_reset();
    @(negedge clk);
    in_valid = 0; lesser = 0; greater = 0; equal = 0; clear = 0;
    model_reset();
    rst = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0] bad_list [5];
    logic [2:0] f;
    bit         bias;
    int         r;

    bad_list = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    lit("reset_tripped", tripped0, 0);
    lit("reset_pulses", {trip_pulse0, release_pulse0, flag_err0}, 0);
    release_reset();

    // three greaters trip; pulse lasts one cycle
    gt();
    lit("deb1_single_gt_trips", tripped1, 1);
    lit("deb1_single_gt_pulse", trip_pulse1, 1);
    gt();
    lit("two_gt_no_trip", tripped0, 0);
    gt();
    lit("three_gt_tripped", tripped0, 1);
    lit("three_gt_pulse", trip_pulse0, 1);
    gap();
    lit("trip_pulse_drops", trip_pulse0, 0);
    lit("tripped_holds", tripped0, 1);

    // equal breaks a run
    clr();
    gt(); gt(); eq(); gt(); gt();
    lit("broken_run_no_trip", tripped0, 0);
    gt();
    lit("rebuilt_run_trips", tripped0, 1);

    // lesser run with invalid gaps releases once
    lt(); gap(); gap(); lt();
    lit("gap_no_early_release", tripped0, 1);
    lt();
    lit("release_pulse", release_pulse0, 1);
    lit("released_level", tripped0, 0);
    gt();
    lit("release_pulse_once", release_pulse0, 0);
    gt();
    lit("no_quick_retrip", tripped0, 0);
    gt();
    lit("retrip_after_three", tripped0, 1);

    // malformed flags in IDLE
    clr();
    gt();
    step(1, 1, 1, 0, 0);
    lit("flag_err_set", flag_err0, 1);
    lit("flag_err_idle", tripped0, 0);
    gap();
    lit("flag_err_one_cycle", flag_err0, 0);
    gt(); gt();
    lit("flag_err_reset_run", tripped0, 0);
    gt();
    lit("trip_after_flag_err", tripped0, 1);

    // clear wins over a valid lesser; no release pulse
    step(1, 1, 0, 0, 1);
    lit("clear_tripped", tripped0, 0);
    lit("clear_no_release", release_pulse0, 0);
`ifdef CMP_TRIP_COUNT_EN
    lit("clear_count", count0, 0);
`endif

    // asynchronous reset while trip pulse is high
    gt(); gt(); gt();
    #2 rst = 1;
    #1;
    lit("async_rst_tripped", tripped0, 0);
    lit("async_rst_pulse", trip_pulse0, 0);
`ifdef CMP_TRIP_COUNT_EN
    lit("async_rst_count", count0, 0);
`endif
    release_reset();

    // asynchronous reset mid-ARM_HI abandons the run
    gt(); gt();
    #2 rst = 1;
    #1;
    lit("async_rst_arm_outputs", {tripped0, trip_pulse0, release_pulse0, flag_err0}, 0);
    release_reset();
    gt(); gt();
    lit("run_abandoned", tripped0, 0);
    gt();
    lit("trip_after_reset", tripped0, 1);
    lit("trip_pulse_after_reset", trip_pulse0, 1);

`ifdef CMP_TRIP_COUNT_EN
    // saturating trip counter: 1,2,3,3,3
    clr();
    for (int t = 0; t < 5; t++) begin
      gt(); gt(); gt();
      lit($sformatf("trip_count_%0d", t), count0, (t < 3) ? t + 1 : 3);
      lt(); lt(); lt();
    end
`endif

    // randomized phase
    clr();
    bias = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) bias = bit'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 5) f = bad_list[$urandom_range(0, 4)];
      else if (r < 15) f = 3'b001;
      else if (r < 78) f = bias ? 3'b010 : 3'b100;
      else f = bias ? 3'b100 : 3'b010;
      step(bit'($urandom_range(0, 9) < 8), f[2], f[1], f[0],
           bit'($urandom_range(0, 249) == 0));
    end

    gap();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: left=%0d expected=0", exp_q.size() + exp1_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
